// File: rtl/dmac_burst_master.sv
// Descriptor-driven DMA master: pops descriptors and copies data_size words in bursts of up to BURST_MAX.
// Each burst holds the bus for 2*B+1 cycles after grant, then releases it for one idle cycle.
module dmac_burst_master #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int SIZE_W    = 16,
  parameter int CNT_W     = 4,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic              op_clear,
  output logic              op_done,
  output logic              rd_en,
  input  logic [CNT_W-1:0]  data_count,
  input  logic [ADDR_W-1:0] source_addr,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [1:0]        op_mode,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int IW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [SIZE_W-1:0] BMAX_S = SIZE_W'(BURST_MAX);
  localparam logic [BW-1:0]     BMAX_B = BW'(BURST_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_POP, S_LOAD, S_REQ, S_RD, S_RDW, S_WR, S_GAP, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [SIZE_W-1:0] rem_q, rem_d;
  logic [1:0]        mode_q, mode_d;
  logic [BW-1:0]     bcnt_q, bcnt_d, k_q, k_d;
  logic              cap_vld_q, cap_vld_d;
  logic [IW-1:0]     cap_idx_q, cap_idx_d;
  logic [DATA_W-1:0] buf_q [BURST_MAX];
  logic [DATA_W-1:0] buf_d [BURST_MAX];
  logic              last_beat;

  assign last_beat = (k_q == bcnt_q - BW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (op_start) state_d = (data_count != '0) ? S_POP : S_DONE;
      S_POP:  state_d = S_LOAD;
      S_LOAD: begin
        if (data_size == '0) state_d = (data_count != '0) ? S_POP : S_DONE;
        else                 state_d = S_REQ;
      end
      S_REQ:  if (m_grant) state_d = S_RD;
      S_RD:   if (last_beat) state_d = S_RDW;
      S_RDW:  state_d = S_WR;
      S_WR: begin
        if (last_beat) begin
          if (rem_q != SIZE_W'(bcnt_q)) state_d = S_GAP;
          else                          state_d = (data_count != '0) ? S_POP : S_DONE;
        end
      end
      S_GAP:  state_d = S_REQ;
      S_DONE: if (op_clear) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data lags its address by one cycle, so each RD beat schedules a capture for the next cycle.
  always_comb begin
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    mode_d    = mode_q;
    bcnt_d    = bcnt_q;
    k_d       = k_q;
    cap_vld_d = 1'b0;
    cap_idx_d = cap_idx_q;
    buf_d     = buf_q;
    if (cap_vld_q) buf_d[cap_idx_q] = m_din;
    case (state_q)
      S_LOAD: begin
        src_d  = source_addr;
        dst_d  = dest_addr;
        rem_d  = data_size;
        mode_d = op_mode;
      end
      S_REQ: begin
        bcnt_d = (rem_q < BMAX_S) ? rem_q[BW-1:0] : BMAX_B;
        k_d    = '0;
      end
      S_RD: begin
        cap_vld_d = 1'b1;
        cap_idx_d = k_q[IW-1:0];
        if (mode_q[0]) src_d = src_q + ADDR_W'(1);
        k_d = last_beat ? '0 : k_q + BW'(1);
      end
      S_WR: begin
        if (mode_q[1]) dst_d = dst_q + ADDR_W'(1);
        k_d = last_beat ? '0 : k_q + BW'(1);
        if (last_beat) rem_d = rem_q - SIZE_W'(bcnt_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      mode_q    <= '0;
      bcnt_q    <= '0;
      k_q       <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      buf_q     <= '{default: '0};
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      mode_q    <= mode_d;
      bcnt_q    <= bcnt_d;
      k_q       <= k_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      buf_q     <= buf_d;
    end
  end

  always_comb begin
    op_done = 1'b0;
    rd_en   = 1'b0;
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_dout  = '0;
    case (state_q)
      S_POP:  rd_en = 1'b1;
      S_REQ:  m_req = 1'b1;
      S_RD: begin
        m_req  = 1'b1;
        m_addr = src_q;
      end
      S_RDW:  m_req = 1'b1;
      S_WR: begin
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = dst_q;
        m_dout = buf_q[k_q[IW-1:0]];
      end
      S_DONE: op_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmac_burst_master.sv
// Bench for dmac_burst_master: FIFO, memory and arbiter models feed the DUT; a bus monitor
// checks every write and every bus tenure length against queues filled when descriptors are issued.
module tb_dmac_burst_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_start = 1'b0, op_clear = 1'b0, op_done, rd_en;
  logic [3:0]  data_count = '0;
  logic [15:0] source_addr = '0, dest_addr = '0, data_size = '0;
  logic [1:0]  op_mode = '0;
  logic        m_req, m_grant = 1'b0, m_wr;
  logic [15:0] m_addr;
  logic [31:0] m_dout, m_din = '0;

  always #5 clk = ~clk;

  dmac_burst_master dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear), .op_done(op_done),
    .rd_en(rd_en), .data_count(data_count), .source_addr(source_addr), .dest_addr(dest_addr),
    .data_size(data_size), .op_mode(op_mode), .m_req(m_req), .m_grant(m_grant), .m_wr(m_wr),
    .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din)
  );

  typedef struct packed { logic [15:0] src, dst, size; logic [1:0] mode; } desc_t;
  typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;

  desc_t fifo_q[$];
  wr_t   exp_wr[$];
  int    exp_run[$];
  int    n_chk = 0, n_fail = 0;
  int    n_runs = 0, n_pops = 0, gnt_delay = 0;

  function automatic logic [31:0] mem_f(logic [15:0] a);
    return {16'hDA7A, a ^ 16'h5A5A};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Queue a descriptor and the bus activity it must produce.
  task automatic push_desc(logic [15:0] s, logic [15:0] d, logic [15:0] sz, logic [1:0] md);
    desc_t x;
    wr_t   w;
    int    r, b;
    x.src = s; x.dst = d; x.size = sz; x.mode = md;
    fifo_q.push_back(x);
    r = int'(sz);
    while (r > 0) begin
      b = (r < 4) ? r : 4;
      for (int k = 0; k < b; k++) begin
        w.addr = d;
        w.data = mem_f(s);
        exp_wr.push_back(w);
        if (md[0]) s = s + 16'd1;
        if (md[1]) d = d + 16'd1;
      end
      exp_run.push_back(2 + gnt_delay + 2 * b);
      r -= b;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && rd_en) begin
      if (fifo_q.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_pop: rd_en with empty descriptor fifo");
      end else begin
        desc_t d;
        d = fifo_q.pop_front();
        source_addr = d.src; dest_addr = d.dst; data_size = d.size; op_mode = d.mode;
        n_pops++;
      end
    end
    data_count = 4'(fifo_q.size());
  end

  logic [15:0] last_addr = '0;
  always @(negedge clk) begin
    m_din     = mem_f(last_addr);
    last_addr = m_addr;
  end

  int wait_cnt = 0;
  always @(negedge clk) begin
    if (m_req) begin
      if (wait_cnt >= gnt_delay) m_grant = 1'b1;
      else begin m_grant = 1'b0; wait_cnt++; end
    end else begin
      m_grant  = 1'b0;
      wait_cnt = 0;
    end
  end

  int   run_len = 0;
  logic prev_req = 1'b0;
  wr_t  mon_e;
  always @(negedge clk) begin
    if (!reset_n) begin
      run_len  = 0;
      prev_req = 1'b0;
    end else begin
      if (m_req && m_wr) begin
        if (exp_wr.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: write to 0x%0h with no expected write", m_addr);
        end else begin
          mon_e = exp_wr.pop_front();
          check("wr_addr", 32'(m_addr), 32'(mon_e.addr));
          check("wr_data", m_dout, mon_e.data);
        end
      end
      if (m_req) run_len++;
      else if (prev_req) begin
        n_runs++;
        if (exp_run.size() == 0) begin
          n_fail++;
          $display("FAIL req_run: tenure of %0d cycles with none expected", run_len);
        end else check("req_run_len", 32'(run_len), 32'(exp_run.pop_front()));
        run_len = 0;
      end
      prev_req = m_req;
    end
  end

  // Start an operation, wait for op_done, verify it holds, then clear it.
  task automatic run_op(output int low_cyc);
    bit seen;
    low_cyc = 0;
    seen = 0;
    repeat (2) @(negedge clk);
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (op_done) break;
      if (m_req) seen = 1;
      else if (seen) low_cyc++;
      @(negedge clk);
    end
    check("op_done_seen", 32'(op_done), 32'd1);
    repeat (3) @(negedge clk);
    check("op_done_hold", 32'(op_done), 32'd1);
    check("wr_left", 32'(exp_wr.size()), 32'd0);
    check("run_left", 32'(exp_run.size()), 32'd0);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    check("op_done_clr", 32'(op_done), 32'd0);
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_m_req"}, 32'(m_req), 32'd0);
    check({tag, "_m_wr"}, 32'(m_wr), 32'd0);
    check({tag, "_m_addr"}, 32'(m_addr), 32'd0);
    check({tag, "_m_dout"}, m_dout, 32'd0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_op_done"}, 32'(op_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, pops0, runs0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    #1 reset_n = 1'b1;

    // 1: three words, incrementing both sides, immediate grant -> one tenure of 8 cycles
    gnt_delay = 0;
    push_desc(16'h0010, 16'h0100, 16'd3, 2'b11);
    run_op(low);
    check("t1_gap", 32'(low), 32'd0);

    // 2: ten words split 4,4,2 with a single idle cycle between tenures
    runs0 = n_runs;
    push_desc(16'h1000, 16'h2000, 16'd10, 2'b11);
    run_op(low);
    check("t2_gap_cycles", 32'(low), 32'd2);
    check("t2_tenures", 32'(n_runs - runs0), 32'd3);

    // 3: zero-length descriptor skipped, second one executes
    pops0 = n_pops; runs0 = n_runs;
    push_desc(16'h0050, 16'h0060, 16'd0, 2'b11);
    push_desc(16'h0070, 16'h0080, 16'd2, 2'b11);
    run_op(low);
    check("t3_pops", 32'(n_pops - pops0), 32'd2);
    check("t3_tenures", 32'(n_runs - runs0), 32'd1);

    // 4: grant held off 5 cycles, fixed addresses -> tenure 6+5 = 11 cycles
    gnt_delay = 5;
    push_desc(16'h0200, 16'h0300, 16'd2, 2'b00);
    run_op(low);
    gnt_delay = 0;

    // 5: source wraps 0xFFFF -> 0x0000, destination fixed
    push_desc(16'hFFFF, 16'h0400, 16'd2, 2'b01);
    run_op(low);

    // 6: reset asserted during the write phase
    push_desc(16'h0010, 16'h0500, 16'd4, 2'b11);
    repeat (2) @(negedge clk);
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (m_wr) break;
      @(negedge clk);
    end
    check("t6_in_wr", 32'(m_wr), 32'd1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    exp_wr.delete();
    exp_run.delete();
    @(negedge clk);
    check_idle_outputs("t6_abort");
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("t6_after");
    runs0 = n_runs;
    run_op(low);
    check("t6_no_bus", 32'(n_runs - runs0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
